// File: rtl/user_io_link_monitor.sv
// Lane-health monitor: debounced per-lane up state, link-down counters, sticky alarms and CSR access.
// Define USER_IO_LINKMON_PUSH_EN to build the flow-controlled status push path on the UIO response port.
module user_io_link_monitor #(
    parameter int unsigned NUM_QSFP        = 2,
    parameter int unsigned LANES           = 4,
    parameter int unsigned UIO_PORTS_WIDTH = 128,
    parameter int unsigned DEBOUNCE_CYCLES = 1024,
    parameter int unsigned CNT_WIDTH       = 16,
    parameter int unsigned PUSH_PERIOD     = 256,
    localparam int unsigned NL             = NUM_QSFP * LANES
) (
    input  logic                       clk_per,
    input  logic                       reset_per,
    input  logic [NL-1:0]              i_lane_up,
    input  logic [NL-1:0]              i_chan_up,
    input  logic [NL-1:0]              i_fatal_alarm,
    input  logic [NL-1:0]              i_corr_alarm,
    input  logic [15:0]                i_csr_addr,
    input  logic [63:0]                i_csr_data,
    input  logic                       i_csr_wr_vld,
    input  logic                       i_csr_rd_vld,
    output logic [63:0]                o_csr_data,
    output logic                       o_csr_rd_ack,
    output logic                       o_uio_rs_vld,
    output logic [UIO_PORTS_WIDTH-1:0] o_uio_rs_data,
    input  logic                       i_uio_rs_afull
);

    localparam int unsigned DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int unsigned SW = 4 * NL;
    localparam logic [63:0] BAD_ADDR_DATA = 64'hdeadbeefdeadbeef;

    typedef enum logic [1:0] {ST_DOWN, ST_DEBOUNCE, ST_UP} lane_st_e;

    logic [SW-1:0]        sync1_q, sync2_q, sync_d;
    logic [NL-1:0]        lane_up_s, chan_up_s, fatal_s, corr_s;
    lane_st_e             state_q [NL];
    lane_st_e             state_d [NL];
    logic [DW-1:0]        dcnt_q [NL];
    logic [DW-1:0]        dcnt_d [NL];
    logic [CNT_WIDTH-1:0] down_cnt_q [NL];
    logic [CNT_WIDTH-1:0] down_cnt_d [NL];
    logic [NL-1:0]        up_vec;
    logic [63:0]          scratch_q, scratch_d;
    logic [NL-1:0]        sticky_fatal_q, sticky_fatal_d;
    logic [NL-1:0]        sticky_corr_q, sticky_corr_d;
    logic [63:0]          csr_data_q, csr_data_d;
    logic                 csr_ack_q, csr_ack_d;
    logic                 cnt_clr_c;
    logic [63:0]          rd_data_c;

    // Two-flop synchronisers for all raw asynchronous inputs.
    assign sync_d    = {i_corr_alarm, i_fatal_alarm, i_chan_up, i_lane_up};
    assign lane_up_s = sync2_q[0*NL +: NL];
    assign chan_up_s = sync2_q[1*NL +: NL];
    assign fatal_s   = sync2_q[2*NL +: NL];
    assign corr_s    = sync2_q[3*NL +: NL];

    always_comb begin
        for (int i = 0; i < NL; i++) begin
            up_vec[i] = (state_q[i] == ST_UP);
        end
    end

    // Per-lane debounce/hysteresis FSM and saturating link-down counter; a clear beats a down event.
    always_comb begin
        state_d    = state_q;
        dcnt_d     = dcnt_q;
        down_cnt_d = down_cnt_q;
        for (int i = 0; i < NL; i++) begin
            case (state_q[i])
                ST_DOWN: begin
                    if (lane_up_s[i]) begin
                        state_d[i] = ST_DEBOUNCE;
                        dcnt_d[i]  = '0;
                    end
                end
                ST_DEBOUNCE: begin
                    if (!lane_up_s[i]) begin
                        state_d[i] = ST_DOWN;
                    end else if (dcnt_q[i] == DW'(DEBOUNCE_CYCLES - 1)) begin
                        state_d[i] = ST_UP;
                    end else begin
                        dcnt_d[i] = dcnt_q[i] + DW'(1);
                    end
                end
                ST_UP: begin
                    if (!lane_up_s[i]) begin
                        state_d[i] = ST_DOWN;
                        if (down_cnt_q[i] != '1) begin
                            down_cnt_d[i] = down_cnt_q[i] + CNT_WIDTH'(1);
                        end
                    end
                end
                default: state_d[i] = ST_DOWN;
            endcase
            if (cnt_clr_c) begin
                down_cnt_d[i] = '0;
            end
        end
    end

    // CSR writes: scratch, W1C sticky alarms (set wins), counter clear.
    always_comb begin
        cnt_clr_c      = i_csr_wr_vld && (i_csr_addr == 16'h0018);
        scratch_d      = scratch_q;
        sticky_fatal_d = sticky_fatal_q;
        sticky_corr_d  = sticky_corr_q;
        if (i_csr_wr_vld && (i_csr_addr == 16'h0008)) begin
            scratch_d = i_csr_data;
        end
        if (i_csr_wr_vld && (i_csr_addr == 16'h0010)) begin
            sticky_fatal_d = sticky_fatal_q & ~i_csr_data[0 +: NL];
            sticky_corr_d  = sticky_corr_q & ~i_csr_data[32 +: NL];
        end
        sticky_fatal_d = sticky_fatal_d | fatal_s;
        sticky_corr_d  = sticky_corr_d | corr_s;
    end

    // CSR read mux; counter window at 0x0100 + 8*lane.
    always_comb begin
        rd_data_c = BAD_ADDR_DATA;
        case (i_csr_addr)
            16'h0000: rd_data_c = {16'h0, 16'(chan_up_s), 16'h0, 16'(up_vec)};
            16'h0008: rd_data_c = scratch_q;
            16'h0010: rd_data_c = {16'h0, 16'(sticky_corr_q), 16'h0, 16'(sticky_fatal_q)};
            16'h0018: rd_data_c = '0;
            default: begin
                if ((i_csr_addr[15:7] == 9'h002) && (i_csr_addr[2:0] == 3'b000)) begin
                    for (int i = 0; i < NL; i++) begin
                        if (i_csr_addr[6:3] == 4'(i)) begin
                            rd_data_c = 64'(down_cnt_q[i]);
                        end
                    end
                end
            end
        endcase
    end

    always_comb begin
        csr_ack_d  = i_csr_rd_vld;
        csr_data_d = i_csr_rd_vld ? rd_data_c : csr_data_q;
    end

    always_ff @(posedge clk_per or posedge reset_per) begin
        if (reset_per) begin
            sync1_q        <= '0;
            sync2_q        <= '0;
            scratch_q      <= '0;
            sticky_fatal_q <= '0;
            sticky_corr_q  <= '0;
            csr_data_q     <= '0;
            csr_ack_q      <= 1'b0;
            for (int i = 0; i < NL; i++) begin
                state_q[i]    <= ST_DOWN;
                dcnt_q[i]     <= '0;
                down_cnt_q[i] <= '0;
            end
        end else begin
            sync1_q        <= sync_d;
            sync2_q        <= sync1_q;
            scratch_q      <= scratch_d;
            sticky_fatal_q <= sticky_fatal_d;
            sticky_corr_q  <= sticky_corr_d;
            csr_data_q     <= csr_data_d;
            csr_ack_q      <= csr_ack_d;
            for (int i = 0; i < NL; i++) begin
                state_q[i]    <= state_d[i];
                dcnt_q[i]     <= dcnt_d[i];
                down_cnt_q[i] <= down_cnt_d[i];
            end
        end
    end

    assign o_csr_data   = csr_data_q;
    assign o_csr_rd_ack = csr_ack_q;

`ifdef USER_IO_LINKMON_PUSH_EN
    localparam int unsigned PW = $clog2(PUSH_PERIOD);

    logic [PW-1:0]              period_q, period_d;
    logic                       pending_q, pending_d;
    logic [NL-1:0]              last_up_q, last_up_d;
    logic                       vld_q, vld_d;
    logic [UIO_PORTS_WIDTH-1:0] data_q, data_d;
    logic [UIO_PORTS_WIDTH-1:0] push_data_c;
    logic                       req_c, fire_c;

    assign push_data_c = UIO_PORTS_WIDTH'({16'(sticky_corr_q), 16'(sticky_fatal_q),
                                           16'(chan_up_s), 16'(up_vec)});

    // Requests coalesce into pending; one cycle gap is forced between pushes.
    always_comb begin
        req_c     = (period_q == PW'(PUSH_PERIOD - 1)) || (up_vec != last_up_q);
        period_d  = (period_q == PW'(PUSH_PERIOD - 1)) ? '0 : period_q + PW'(1);
        fire_c    = (pending_q || req_c) && !i_uio_rs_afull && !vld_q;
        pending_d = (pending_q || req_c) && !fire_c;
        vld_d     = fire_c;
        data_d    = fire_c ? push_data_c : '0;
        last_up_d = fire_c ? up_vec : last_up_q;
    end

    always_ff @(posedge clk_per or posedge reset_per) begin
        if (reset_per) begin
            period_q  <= '0;
            pending_q <= 1'b0;
            last_up_q <= '0;
            vld_q     <= 1'b0;
            data_q    <= '0;
        end else begin
            period_q  <= period_d;
            pending_q <= pending_d;
            last_up_q <= last_up_d;
            vld_q     <= vld_d;
            data_q    <= data_d;
        end
    end

    assign o_uio_rs_vld  = vld_q;
    assign o_uio_rs_data = data_q;
`else
    logic unused_afull;

    assign unused_afull  = i_uio_rs_afull;
    assign o_uio_rs_vld  = 1'b0;
    assign o_uio_rs_data = '0;
`endif

endmodule

// File: tb/tb_user_io_link_monitor.sv
// Scoreboarded bench for user_io_link_monitor: CSR reads checked by a monitor against queued expectations.
module tb_user_io_link_monitor;

    localparam int unsigned NL  = 8;
    localparam int unsigned UW  = 128;
    localparam int unsigned DEB = 8;
    localparam int unsigned PP  = 32;
    localparam logic [63:0] DEAD = 64'hdeadbeefdeadbeef;
    localparam logic [63:0] S0   = 64'h0000_00a5_0000_0000;

    logic           clk_per = 1'b0;
    logic           reset_per = 1'b1;
    logic [NL-1:0]  i_lane_up = '0;
    logic [NL-1:0]  i_chan_up = '0;
    logic [NL-1:0]  i_fatal_alarm = '0;
    logic [NL-1:0]  i_corr_alarm = '0;
    logic [15:0]    i_csr_addr = '0;
    logic [63:0]    i_csr_data = '0;
    logic           i_csr_wr_vld = 1'b0;
    logic           i_csr_rd_vld = 1'b0;
    logic [63:0]    o_csr_data;
    logic           o_csr_rd_ack;
    logic           o_uio_rs_vld;
    logic [UW-1:0]  o_uio_rs_data;
    logic           i_uio_rs_afull = 1'b0;

    int checks = 0;
    int errors = 0;
    int vld_seen = 0;
    logic [63:0] exp_q[$];
    string       name_q[$];
    logic [63:0] mon_exp;
    string       mon_name;

    user_io_link_monitor #(
        .NUM_QSFP(2), .LANES(4), .UIO_PORTS_WIDTH(UW),
        .DEBOUNCE_CYCLES(DEB), .CNT_WIDTH(16), .PUSH_PERIOD(PP)
    ) dut (
        .clk_per(clk_per), .reset_per(reset_per),
        .i_lane_up(i_lane_up), .i_chan_up(i_chan_up),
        .i_fatal_alarm(i_fatal_alarm), .i_corr_alarm(i_corr_alarm),
        .i_csr_addr(i_csr_addr), .i_csr_data(i_csr_data),
        .i_csr_wr_vld(i_csr_wr_vld), .i_csr_rd_vld(i_csr_rd_vld),
        .o_csr_data(o_csr_data), .o_csr_rd_ack(o_csr_rd_ack),
        .o_uio_rs_vld(o_uio_rs_vld), .o_uio_rs_data(o_uio_rs_data),
        .i_uio_rs_afull(i_uio_rs_afull)
    );

    always #5 clk_per = ~clk_per;

    // Monitor: every read ack pops one expectation.
    always @(negedge clk_per) begin
        if (o_uio_rs_vld) vld_seen++;
        if (o_csr_rd_ack) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_ack got %h required no ack", o_csr_data);
            end else begin
                mon_exp  = exp_q.pop_front();
                mon_name = name_q.pop_front();
                if (o_csr_data !== mon_exp) begin
                    errors++;
                    $display("FAIL %s got %h required %h", mon_name, o_csr_data, mon_exp);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk_per);
            #1;
        end
    endtask

    task automatic chk(input string nm, input logic [UW-1:0] act, input logic [UW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h required %h", nm, act, exp);
        end
    endtask

    task automatic csr_rd(input logic [15:0] a, input logic [63:0] e, input string nm);
        i_csr_addr   = a;
        i_csr_rd_vld = 1'b1;
        exp_q.push_back(e);
        name_q.push_back(nm);
        tick(1);
        i_csr_rd_vld = 1'b0;
    endtask

    task automatic csr_wr(input logic [15:0] a, input logic [63:0] d);
        i_csr_addr   = a;
        i_csr_data   = d;
        i_csr_wr_vld = 1'b1;
        tick(1);
        i_csr_wr_vld = 1'b0;
    endtask

    task automatic csr_rdwr(input logic [15:0] a, input logic [63:0] d, input logic [63:0] e,
                            input string nm);
        i_csr_data   = d;
        i_csr_wr_vld = 1'b1;
        csr_rd(a, e, nm);
        i_csr_wr_vld = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int v0;
        bit found;
        logic [UW-1:0] pdata;

        tick(2);
        chk("reset_ack", UW'(o_csr_rd_ack), '0);
        chk("reset_csr_data", UW'(o_csr_data), '0);
        chk("reset_vld", UW'(o_uio_rs_vld), '0);
        chk("reset_rs_data", o_uio_rs_data, '0);
        reset_per = 1'b0;
        tick(1);
        csr_rd(16'h0000, 64'h0, "status_reset");
        i_chan_up = 8'ha5;
        tick(3);

        csr_wr(16'h0008, 64'h1234_5678_9abc_def0);
        csr_rd(16'h0008, 64'h1234_5678_9abc_def0, "scratch");
        csr_rdwr(16'h0008, 64'hcafe, 64'h1234_5678_9abc_def0, "scratch_rd_wr_same");
        csr_rd(16'h0008, 64'hcafe, "scratch_new");

        // Lane 0 rise: up exactly DEB+3 cycles after the raw edge.
        i_lane_up[0] = 1'b1;
        tick(10);
        csr_rd(16'h0000, S0, "status_before_up");
        csr_rd(16'h0000, S0 | 64'h1, "status_up");
`ifdef USER_IO_LINKMON_PUSH_EN
        found = 1'b0;
        pdata = '0;
        for (int k = 0; k < 4 && !found; k++) begin
            if (o_uio_rs_vld && o_uio_rs_data[0]) begin
                found = 1'b1;
                pdata = o_uio_rs_data;
            end else begin
                tick(1);
            end
        end
        chk("change_push_seen", UW'(found), UW'(1));
        chk("change_push_data", pdata, UW'(64'h0000_0000_00a5_0001));
`endif

        // Lane 1 drops before debounce completes.
        i_lane_up[1] = 1'b1;
        tick(5);
        i_lane_up[1] = 1'b0;
        tick(12);
        csr_rd(16'h0000, S0 | 64'h1, "lane1_never_up");
        csr_rd(16'h0108, 64'h0, "lane1_down_cnt");

        // Lane 2 cycled up/down three times.
        for (int r = 0; r < 3; r++) begin
            i_lane_up[2] = 1'b1;
            tick(13);
            csr_rd(16'h0000, S0 | 64'h5, "lane2_up");
            i_lane_up[2] = 1'b0;
            tick(5);
        end
        csr_rd(16'h0110, 64'd3, "lane2_down_cnt");
        csr_rd(16'h0100, 64'd0, "lane0_down_cnt");
        csr_wr(16'h0018, 64'h1);
        csr_rd(16'h0110, 64'd0, "down_cnt_cleared");
        csr_rd(16'h0018, 64'd0, "clr_reg_reads0");

        // Clear lands on the same edge as the UP->DOWN event.
        i_lane_up[2] = 1'b1;
        tick(14);
        i_lane_up[2] = 1'b0;
        tick(2);
        csr_wr(16'h0018, 64'h1);
        tick(2);
        csr_rd(16'h0110, 64'd0, "clear_beats_down");
        i_lane_up[2] = 1'b1;
        tick(14);
        i_lane_up[2] = 1'b0;
        tick(5);
        csr_rd(16'h0110, 64'd1, "down_cnt_after_clear");

        // Sticky alarms.
        i_fatal_alarm[3] = 1'b1;
        tick(1);
        i_fatal_alarm[3] = 1'b0;
        tick(4);
        csr_rd(16'h0010, 64'h8, "sticky_fatal");
        i_fatal_alarm[3] = 1'b1;
        tick(1);
        i_fatal_alarm[3] = 1'b0;
        tick(1);
        csr_wr(16'h0010, 64'h8);
        tick(1);
        csr_rd(16'h0010, 64'h8, "sticky_set_wins");
        csr_wr(16'h0010, 64'h8);
        csr_rd(16'h0010, 64'h0, "sticky_w1c");
        i_corr_alarm[5] = 1'b1;
        tick(1);
        i_corr_alarm[5] = 1'b0;
        tick(4);
        csr_rd(16'h0010, 64'h0000_0020_0000_0000, "sticky_corr");
        csr_wr(16'h0010, 64'h0000_0000_0000_0020);
        csr_rd(16'h0010, 64'h0000_0020_0000_0000, "sticky_w1c_other_bit");
        csr_wr(16'h0010, 64'h0000_0020_0000_0000);
        csr_rd(16'h0010, 64'h0, "sticky_corr_w1c");

        // Address decode edges.
        csr_rd(16'h0200, DEAD, "bad_addr");
        csr_rd(16'h0104, DEAD, "unaligned_cnt");
        csr_rd(16'h0140, DEAD, "cnt_idx_oob");
        csr_rd(16'h0138, 64'h0, "cnt_last_lane");

`ifdef USER_IO_LINKMON_PUSH_EN
        i_uio_rs_afull = 1'b1;
        tick(2);
        v0 = vld_seen;
        tick(3 * PP + 4);
        chk("afull_blocks_push", UW'(vld_seen - v0), '0);
        i_uio_rs_afull = 1'b0;
        tick(1);
        chk("release_vld", UW'(o_uio_rs_vld), UW'(1));
        chk("release_data", o_uio_rs_data, UW'(64'h0000_0000_00a5_0001));
        tick(1);
        chk("no_back_to_back", UW'(o_uio_rs_vld), '0);
`else
        chk("push_disabled_vld", UW'(vld_seen), '0);
        chk("push_disabled_data", o_uio_rs_data, '0);
`endif

        // Reset in the middle of a debounce.
        i_lane_up[3] = 1'b1;
        tick(5);
        i_csr_addr   = 16'h0200;
        i_csr_rd_vld = 1'b1;
        exp_q.push_back(DEAD);
        name_q.push_back("pre_reset_read");
        tick(1);
        i_csr_rd_vld = 1'b0;
        tick(1);
        chk("pre_reset_data", UW'(o_csr_data), UW'(DEAD));
        reset_per = 1'b1;
        #1;
        chk("rst_ack", UW'(o_csr_rd_ack), '0);
        chk("rst_csr_data", UW'(o_csr_data), '0);
        chk("rst_vld", UW'(o_uio_rs_vld), '0);
        v0 = vld_seen;
        tick(3);
        chk("rst_no_push", UW'(vld_seen - v0), '0);
        reset_per = 1'b0;
        tick(3);
        csr_rd(16'h0000, S0, "status_after_reset");
        csr_rd(16'h0008, 64'h0, "scratch_after_reset");
        csr_rd(16'h0110, 64'h0, "down_cnt_after_reset");
        tick(12);
        csr_rd(16'h0000, S0 | 64'h9, "relink_after_reset");

        tick(4);
        chk("scoreboard_drained", UW'(exp_q.size()), '0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/user_io_link_monitor.md
# user_io_link_monitor

Parametrised link-health monitor for the user-IO black box. It tracks every transceiver lane across NUM_QSFP cages, debounces lane-up and applies hysteresis, and counts link-down events. It latches fatal/correctable alarms as sticky bits and exposes everything through the existing 16-bit-address CSR port. It also drives the reserved status UIO response port with flow-controlled, change-triggered and periodic status pushes, replacing the fixed-width free-running status register.

## Interface
Parameters:
- NUM_QSFP, 2: number of QSFP cages, 1..4.
- LANES, 4: lanes per cage, 1..4; NL = NUM_QSFP*LANES (max 16).
- UIO_PORTS_WIDTH, 128: status push data width, ≥ 64.
- DEBOUNCE_CYCLES, 1024: cycles lane-up must hold before a lane is declared up, ≥ 2.
- CNT_WIDTH, 16: link-down counter width, saturating.
- PUSH_PERIOD, 256: cycles between periodic status pushes, ≥ 4.

Ports:
- Clock and reset: one clock, clk_per; reset_per is asynchronous, active-high.
- clk_per  in  1  sole clock.
- reset_per  in  1  asynchronous active-high reset.
- i_lane_up  in  NL  raw lane-up, asynchronous domain.
- i_chan_up  in  NL  raw channel-up, asynchronous domain.
- i_fatal_alarm  in  NL  raw fatal alarm, asynchronous domain.
- i_corr_alarm  in  NL  raw correctable alarm, asynchronous domain.
- i_csr_addr  in  16  CSR byte address.
- i_csr_data  in  64  CSR write data.
- i_csr_wr_vld  in  1  write strobe.
- i_csr_rd_vld  in  1  read strobe.
- o_csr_data  out  64  read data; reset 0.
- o_csr_rd_ack  out  1  read acknowledge; reset 0.
- o_uio_rs_vld  out  1  status push valid; reset 0.
- o_uio_rs_data  out  UIO_PORTS_WIDTH  status push data; reset 0.
- i_uio_rs_afull  in  1  downstream almost-full.

## Operation
- All four raw input vectors pass through 2-flop synchronisers, which reset to 0.
- Per-lane FSM with states DOWN, DEBOUNCE and UP:
  - DOWN → DEBOUNCE when the synced lane_up is 1; the counter loads 0.
  - In DEBOUNCE, the counter increments each cycle. A drop of lane_up returns the lane to DOWN.
  - DEBOUNCE → UP when count == DEBOUNCE_CYCLES-1 and lane_up is still 1.
  - UP → DOWN when lane_up is 0. This increments the lane's down_cnt, which saturates at all-ones.
  - up_vec[i] = (state == UP).
- Sticky alarms: a sticky bit sets on a synced alarm bit being 1. It clears by CSR write-1-to-clear. If set and clear occur in the same cycle, set wins.
- CSR map (one read per strobe):
  - 0x0000 status = {zeros, chan_up_sync[NL-1:0] at [47:32], up_vec at [15:0]}.
  - 0x0008 scratch, R/W.
  - 0x0010 sticky: fatal at [15:0], corr at [47:32]; W1C.
  - 0x0018 write any value: clears all down_cnt. Reads 0.
  - 0x0100+8*i (i < NL): down_cnt[i], zero-extended. Read-only.
  - Any other address: reads 64'hdeadbeefdeadbeef; writes are ignored.
- Counter clear coinciding with a down event: clear wins, and the counter reads 0.
- Status push data = {zeros, sticky_corr[15:0], sticky_fatal[15:0], chan_up_sync[15:0], up_vec[15:0]}, with each field zero-extended to 16 bits.
- Push request sources:
  - The period counter reaching PUSH_PERIOD-1, after which it wraps to 0.
  - Any change of up_vec relative to the last pushed value.
- A request sets `pending`. When pending is 1 and i_uio_rs_afull is 0, the block drives one o_uio_rs_vld pulse with current data and clears pending. Multiple requests while pending coalesce into one push.

## Timing
- CSR: o_csr_rd_ack and o_csr_data are registered, 1 cycle after i_csr_rd_vld. A write takes effect on the next clock edge.
- A read and write to the same address in the same cycle returns the pre-write value.
- Lane rise: a raw rise held steady sets up_vec exactly DEBOUNCE_CYCLES+3 cycles later (2 sync + 1 entry + DEBOUNCE_CYCLES).
- Lane fall: a raw fall clears up_vec 3 cycles later.
- Push: o_uio_rs_vld asserts 1 cycle after the request when afull is low; o_uio_rs_data is valid only with vld. Pushes are never back-to-back.
- reset_per asserted mid-operation: all FSMs go to DOWN, counters, sticky bits, scratch, pending and outputs go to 0, and the period counter goes to 0. No push is generated while reset is asserted.

## Configuration
- USER_IO_LINKMON_PUSH_EN defined: the status push path is built as described.
- USER_IO_LINKMON_PUSH_EN undefined: the period counter and pending logic are not built. o_uio_rs_vld is tied 0, o_uio_rs_data is tied 0, and i_uio_rs_afull is ignored. CSR behaviour is unchanged.

## Test plan
- DEBOUNCE_CYCLES=8; raise i_lane_up[0] and hold it → status bit0 = 1 exactly 11 cycles later; a change-push follows with data[0] = 1.
- Raise lane 1, then drop it after 5 synced-high cycles → never UP, and down_cnt[1] stays 0.
- Cycle lane 2 UP→DOWN 3 times → CSR 0x0110 reads 3. Write 0x0018, then read again → 0.
- Pulse i_fatal_alarm[3] → 0x0010 reads 0x8. Write 0x8 in the same cycle the alarm re-fires → the bit stays 1.
- Hold i_uio_rs_afull=1 over 3 push periods → no vld. Release it → exactly one vld 1 cycle later.
- Read 0x0200 → ack after 1 cycle with data 0xdeadbeefdeadbeef. Assert reset mid-DEBOUNCE → all outputs 0 immediately.
